// File: rtl/xbar_sched.sv
// xbar_sched: select-pattern sequencer for the distribution crossbar.
//
// Holds a CFG_DEPTH-entry table of crossbar select patterns. A run starts
// with i_start and walks the first num_cfg entries round-robin, presenting
// one pattern on o_mux_bus per accepted input vector. o_dist_valid follows
// each accepted vector by one cycle, matching the crossbar's registered
// output stage.
//
// Ports:
//   clk, rst        clock (rising edge) and synchronous active-low reset
//   i_cfg_wr_*      table write port (honoured only while idle)
//   i_cfg_num       active table entries for the next run (0 or >CFG_DEPTH -> CFG_DEPTH)
//   i_num_vec       vectors in the next run (0 -> immediate done)
//   i_start         start pulse (honoured only while idle)
//   i_data_valid    upstream vector present
//   o_data_ready    vector accepted this cycle when i_data_valid is also high
//   o_mux_bus       select pattern for the current beat, 0 outside a run
//   o_dist_valid    crossbar output holds a valid vector
//   o_busy, o_done  run in progress / one-cycle end-of-run pulse
//
// Handshake: a vector transfers on every rising edge where
// i_data_valid && o_data_ready. o_data_ready depends only on registered
// state, never on i_data_valid, and upstream may drop i_data_valid at will.
module xbar_sched #(
  parameter int NUM_PES   = 4,
  parameter int LOG2_PES  = 2,
  parameter int CFG_DEPTH = 4,
  parameter int LOG2_CFG  = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_cfg_wr_en,
  input  logic [LOG2_CFG-1:0]          i_cfg_wr_addr,
  input  logic [LOG2_PES*NUM_PES-1:0]  i_cfg_wr_data,
  input  logic [LOG2_CFG:0]            i_cfg_num,
  input  logic [15:0]                  i_num_vec,
  input  logic                         i_start,
  input  logic                         i_data_valid,
  output logic                         o_data_ready,
  output logic [LOG2_PES*NUM_PES-1:0]  o_mux_bus,
  output logic                         o_dist_valid,
  output logic                         o_busy,
  output logic                         o_done
);

  localparam int SEL_W = LOG2_PES * NUM_PES;
  localparam logic [LOG2_CFG:0] FULL_CFG = (LOG2_CFG+1)'(CFG_DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // state_q is the observable FSM state for external checkers.
  state_e              state_q, state_d;
  logic [LOG2_CFG-1:0] ptr_q, ptr_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [LOG2_CFG:0]   num_cfg_q, num_cfg_d;
  logic [SEL_W-1:0]    table_q [CFG_DEPTH];
  logic [SEL_W-1:0]    table_d [CFG_DEPTH];
  logic                dist_valid_q, dist_valid_d;
  logic                handshake;

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    cnt_d        = cnt_q;
    num_cfg_d    = num_cfg_q;
    table_d      = table_q;
    o_data_ready = 1'b0;
    o_busy       = 1'b0;
    o_done       = 1'b0;
    o_mux_bus    = '0;
    handshake    = 1'b0;

    case (state_q)
      IDLE: begin
        // The write lands in the same edge as start, so the run's first
        // table read (next cycle) already sees the new entry.
        if (i_cfg_wr_en) begin
          table_d[i_cfg_wr_addr] = i_cfg_wr_data;
        end
        if (i_start) begin
          if ((i_cfg_num == '0) || (i_cfg_num > FULL_CFG)) begin
            num_cfg_d = FULL_CFG;
          end else begin
            num_cfg_d = i_cfg_num;
          end
          cnt_d   = i_num_vec;
          ptr_d   = '0;
          state_d = (i_num_vec != 16'd0) ? RUN : DONE;
        end
      end

      RUN: begin
        o_busy       = 1'b1;
        o_data_ready = 1'b1;
        o_mux_bus    = table_q[ptr_q];
        handshake    = i_data_valid;
        if (handshake) begin
          if ({1'b0, ptr_q} == (num_cfg_q - 1'b1)) begin
            ptr_d = '0;
          end else begin
            ptr_d = ptr_q + 1'b1;
          end
          cnt_d = cnt_q - 16'd1;
          if (cnt_q == 16'd1) begin
            state_d = DONE;
          end
        end
      end

      DONE: begin
        o_done  = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Crossbar output register is one cycle behind the accepted beat,
    // regardless of what the FSM does next.
    dist_valid_d = handshake;
  end

  assign o_dist_valid = dist_valid_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      cnt_q        <= '0;
      num_cfg_q    <= '0;
      dist_valid_q <= 1'b0;
      for (int i = 0; i < CFG_DEPTH; i++) begin
        table_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      num_cfg_q    <= num_cfg_d;
      dist_valid_q <= dist_valid_d;
      table_q      <= table_d;
    end
  end

endmodule

// File: tb/tb_xbar_sched.sv
// Directed bench for xbar_sched: table programming, round-robin pattern
// streaming with continuous and gapped valid, zero-length runs, entry-count
// clamping, writes/starts ignored during a run, and mid-run reset.
module tb_xbar_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_cfg_wr_en;
  logic [1:0]  i_cfg_wr_addr;
  logic [7:0]  i_cfg_wr_data;
  logic [2:0]  i_cfg_num;
  logic [15:0] i_num_vec;
  logic        i_start;
  logic        i_data_valid;
  logic        o_data_ready;
  logic [7:0]  o_mux_bus;
  logic        o_dist_valid;
  logic        o_busy;
  logic        o_done;

  int vec_cnt = 0;
  int err_cnt = 0;

  // Expected o_mux_bus pattern for each remaining beat of the current run.
  logic [7:0] exp_q[$];

  // Clock / reset block
  always #5 clk = ~clk;

  xbar_sched dut (
    .clk           (clk),
    .rst           (rst),
    .i_cfg_wr_en   (i_cfg_wr_en),
    .i_cfg_wr_addr (i_cfg_wr_addr),
    .i_cfg_wr_data (i_cfg_wr_data),
    .i_cfg_num     (i_cfg_num),
    .i_num_vec     (i_num_vec),
    .i_start       (i_start),
    .i_data_valid  (i_data_valid),
    .o_data_ready  (o_data_ready),
    .o_mux_bus     (o_mux_bus),
    .o_dist_valid  (o_dist_valid),
    .o_busy        (o_busy),
    .o_done        (o_done)
  );

  initial begin
    #200000;
    $display("FAIL timeout: simulation ran past its time limit");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; land 1ns after the edge to drive and sample.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".busy"},  o_busy,       1'b0);
    chk({tag, ".ready"}, o_data_ready, 1'b0);
    chk({tag, ".mux"},   o_mux_bus,    8'h00);
    chk({tag, ".done"},  o_done,       1'b0);
  endtask

  // Driver tasks
  task automatic cfg_write(input logic [1:0] addr, input logic [7:0] data);
    i_cfg_wr_en   = 1'b1;
    i_cfg_wr_addr = addr;
    i_cfg_wr_data = data;
    step();
    i_cfg_wr_en   = 1'b0;
  endtask

  task automatic start_run(input logic [2:0] cfg_num, input logic [15:0] num_vec);
    i_cfg_num = cfg_num;
    i_num_vec = num_vec;
    i_start   = 1'b1;
    step();
    i_start   = 1'b0;
  endtask

  // Streams the beats held in exp_q. vpat bit (c % 16) is i_data_valid in
  // RUN cycle c. In cycle inj_cyc a table[0] write and a start are also
  // driven; both must be ignored. Ends after checking DONE and the return
  // to IDLE. Loop length comes from the model, so it cannot hang.
  task automatic run_beats(input string tag, input logic [15:0] vpat, input int inj_cyc);
    logic prev_hs;
    logic v;
    prev_hs = 1'b0;
    for (int c = 0; c < 64 && exp_q.size() > 0; c++) begin
      v = vpat[c % 16];
      i_data_valid = v;
      if (c == inj_cyc) begin
        i_cfg_wr_en   = 1'b1;
        i_cfg_wr_addr = 2'd0;
        i_cfg_wr_data = 8'hFF;
        i_start       = 1'b1;
        i_num_vec     = 16'd9;
      end else begin
        i_cfg_wr_en   = 1'b0;
        i_start       = 1'b0;
      end
      chk($sformatf("%s.c%0d.ready", tag, c), o_data_ready, 1'b1);
      chk($sformatf("%s.c%0d.busy",  tag, c), o_busy,       1'b1);
      chk($sformatf("%s.c%0d.done",  tag, c), o_done,       1'b0);
      chk($sformatf("%s.c%0d.mux",   tag, c), o_mux_bus,    exp_q[0]);
      chk($sformatf("%s.c%0d.dv",    tag, c), o_dist_valid, prev_hs);
      prev_hs = v;
      if (v) void'(exp_q.pop_front());
      step();
    end
    i_data_valid = 1'b0;
    i_cfg_wr_en  = 1'b0;
    i_start      = 1'b0;
    chk({tag, ".done_cyc.done"},  o_done,       1'b1);
    chk({tag, ".done_cyc.busy"},  o_busy,       1'b0);
    chk({tag, ".done_cyc.ready"}, o_data_ready, 1'b0);
    chk({tag, ".done_cyc.dv"},    o_dist_valid, 1'b1);
    chk({tag, ".done_cyc.mux"},   o_mux_bus,    8'h00);
    step();
    chk_idle({tag, ".after"});
    chk({tag, ".after.dv"}, o_dist_valid, 1'b0);
  endtask

  initial begin
    rst           = 1'b0;
    i_cfg_wr_en   = 1'b0;
    i_cfg_wr_addr = '0;
    i_cfg_wr_data = '0;
    i_cfg_num     = '0;
    i_num_vec     = '0;
    i_start       = 1'b0;
    i_data_valid  = 1'b0;

    // Reset state
    step();
    step();
    chk_idle("reset");
    chk("reset.dv", o_dist_valid, 1'b0);
    rst = 1'b1;
    step();

    // 1: two entries, five vectors, valid held high
    cfg_write(2'd0, 8'hE4);
    cfg_write(2'd1, 8'h1B);
    chk_idle("t1.pre");
    start_run(3'd2, 16'd5);
    exp_q = '{8'hE4, 8'h1B, 8'hE4, 8'h1B, 8'hE4};
    run_beats("t1", 16'hFFFF, -1);

    // 2: gapped valid 1,0,0,1,1,0,1,1
    start_run(3'd2, 16'd5);
    exp_q = '{8'hE4, 8'h1B, 8'hE4, 8'h1B, 8'hE4};
    run_beats("t2", 16'h00D9, -1);

    // 3: zero-length run goes straight to DONE
    i_data_valid = 1'b1;
    start_run(3'd2, 16'd0);
    chk("t3.done",  o_done,       1'b1);
    chk("t3.busy",  o_busy,       1'b0);
    chk("t3.ready", o_data_ready, 1'b0);
    chk("t3.mux",   o_mux_bus,    8'h00);
    step();
    chk_idle("t3.after");
    chk("t3.after.dv", o_dist_valid, 1'b0);
    i_data_valid = 1'b0;

    // 4: cfg_num=0 clamps to all four entries
    cfg_write(2'd2, 8'h4E);
    cfg_write(2'd3, 8'hB1);
    start_run(3'd0, 16'd6);
    exp_q = '{8'hE4, 8'h1B, 8'h4E, 8'hB1, 8'hE4, 8'h1B};
    run_beats("t4", 16'hFFFF, -1);

    // 5: write + start during RUN are ignored
    start_run(3'd3, 16'd4);
    exp_q = '{8'hE4, 8'h1B, 8'h4E, 8'hE4};
    run_beats("t5", 16'hFFFF, 1);
    // Follow-up run also checks clamping of cfg_num > CFG_DEPTH;
    // table[0] must still read E4.
    start_run(3'd7, 16'd5);
    exp_q = '{8'hE4, 8'h1B, 8'h4E, 8'hB1, 8'hE4};
    run_beats("t5b", 16'hFFFF, -1);

    // 6: reset during the 3rd beat
    i_data_valid = 1'b1;
    start_run(3'd2, 16'd5);
    chk("t6.b0.mux", o_mux_bus, 8'hE4);
    step();
    chk("t6.b1.mux", o_mux_bus, 8'h1B);
    step();
    chk("t6.b2.mux", o_mux_bus, 8'hE4);
    rst = 1'b0;
    step();
    rst = 1'b1;
    i_data_valid = 1'b0;
    chk_idle("t6.rst");
    chk("t6.rst.dv", o_dist_valid, 1'b0);
    step();
    chk_idle("t6.post");
    step();
    chk("t6.post2.done", o_done, 1'b0);
    // Table was cleared, so every entry now reads 0.
    start_run(3'd4, 16'd4);
    exp_q = '{8'h00, 8'h00, 8'h00, 8'h00};
    run_beats("t6new", 16'hFFFF, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
